// File: rtl/load_store_unit.sv
// load_store_unit: sequences data_mem accesses for one load/store request at a time.
// Aligned accesses go straight through; misaligned loads become two word reads that
// are merged and extended here; misaligned stores become a run of byte writes.
// Latency from accept to lsu_done_o: fault/trap 1, aligned store 2, aligned load 3,
// misaligned load 5, misaligned store n+1 (n = access bytes).
// Backpressure: lsu_ready_o is high only in IDLE; lsu_req_i is ignored otherwise.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests complete immediately with
// lsu_misaligned_o=1 instead of being split.
// Ports: clk/reset; lsu_* request/response side toward execute; dmem_* toward data_mem.
module load_store_unit #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req_i,
  output logic        lsu_ready_o,
  input  logic        lsu_wr_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_zero_extnd_i,
  input  logic [31:0] lsu_wr_data_i,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rd_data_o,
  output logic        lsu_fault_o,
  output logic        lsu_misaligned_o,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  output logic [1:0]  dmem_byte_en_o,
  output logic        dmem_wr_o,
  output logic [31:0] dmem_wr_data_o,
  output logic        dmem_zero_extnd_o,
  input  logic [31:0] dmem_rd_data_i
);

  localparam logic [1:0]  BYTE      = 2'b00;
  localparam logic [1:0]  HALF_WORD = 2'b01;
  localparam logic [1:0]  WORD      = 2'b10;
  localparam logic [31:0] WORDS_L   = 32'(DMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, ISSUE_HI, CAPTURE_HI, STORE_BYTES, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d, zext_q, zext_d, split_q, split_d, fault_q, fault_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
  logic [1:0]  size_q, size_d, k_q, k_d;
  // Last driven dmem bus values, so the bus holds outside issuing states.
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]  hben_q, hben_d;
  logic        hzext_q, hzext_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
`endif

  logic        mis_in, fault_in;
  logic [29:0] next_word_in;
  logic [31:0] merged;
  logic [7:0]  st_byte;
  logic [1:0]  last_k;

  assign mis_in = ((lsu_size_i == HALF_WORD) && lsu_addr_i[0]) ||
                  ((lsu_size_i == WORD) && (lsu_addr_i[1:0] != 2'b00));
  // Word index of A+4 with 32-bit wrap is just the word index plus one, mod 2^30.
  assign next_word_in = lsu_addr_i[31:2] + 30'd1;
  assign fault_in = ({2'b00, lsu_addr_i[31:2]} >= WORDS_L) ||
                    (mis_in && ({2'b00, next_word_in} >= WORDS_L));

  // Hi word arrives on dmem_rd_data_i in CAPTURE_HI; lo word already sits in res_q.
  assign merged  = 32'({dmem_rd_data_i, res_q} >> {addr_q[1:0], 3'b000});
  assign st_byte = 8'(wdata_q >> {k_q, 3'b000});
  assign last_k  = (size_q == HALF_WORD) ? 2'd1 : 2'd3;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    size_d  = size_q;
    zext_d  = zext_q;
    wdata_d = wdata_q;
    split_d = split_q;
    fault_d = fault_q;
    k_d     = k_q;
    res_d   = res_q;
`ifdef LSU_MISALIGN_TRAP_EN
    trap_d  = trap_q;
`endif
    lsu_ready_o       = 1'b0;
    lsu_done_o        = 1'b0;
    lsu_rd_data_o     = '0;
    lsu_fault_o       = 1'b0;
    lsu_misaligned_o  = 1'b0;
    dmem_req_o        = 1'b0;
    dmem_wr_o         = 1'b0;
    dmem_addr_o       = haddr_q;
    dmem_byte_en_o    = hben_q;
    dmem_wr_data_o    = hwdata_q;
    dmem_zero_extnd_o = hzext_q;

    unique case (state_q)
      IDLE: begin
        lsu_ready_o = 1'b1;
        if (lsu_req_i) begin
          wr_d    = lsu_wr_i;
          addr_d  = lsu_addr_i;
          size_d  = lsu_size_i;
          zext_d  = lsu_zero_extnd_i;
          wdata_d = lsu_wr_data_i;
          split_d = mis_in;
          fault_d = fault_in;
          k_d     = 2'd0;
          res_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          trap_d  = mis_in && !fault_in;
          if (fault_in || mis_in)      state_d = DONE;
`else
          if (fault_in)                state_d = DONE;
`endif
          else if (mis_in && lsu_wr_i) state_d = STORE_BYTES;
          else                         state_d = ISSUE;
        end
      end
      ISSUE: begin
        dmem_req_o     = 1'b1;
        dmem_wr_o      = wr_q;
        dmem_wr_data_o = wdata_q;
        if (split_q) begin
          dmem_addr_o       = {addr_q[31:2], 2'b00};
          dmem_byte_en_o    = WORD;
          dmem_zero_extnd_o = 1'b0;
        end else begin
          dmem_addr_o       = addr_q;
          dmem_byte_en_o    = size_q;
          dmem_zero_extnd_o = zext_q;
        end
        state_d = wr_q ? DONE : CAPTURE;
      end
      CAPTURE: begin
        res_d   = dmem_rd_data_i;
        state_d = split_q ? ISSUE_HI : DONE;
      end
      ISSUE_HI: begin
        dmem_req_o        = 1'b1;
        dmem_addr_o       = {addr_q[31:2] + 30'd1, 2'b00};
        dmem_byte_en_o    = WORD;
        dmem_zero_extnd_o = 1'b0;
        state_d           = CAPTURE_HI;
      end
      CAPTURE_HI: begin
        if (size_q == HALF_WORD)
          res_d = zext_q ? {16'h0000, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
        else
          res_d = merged;
        state_d = DONE;
      end
      STORE_BYTES: begin
        dmem_req_o     = 1'b1;
        dmem_wr_o      = 1'b1;
        dmem_addr_o    = addr_q + {30'd0, k_q};
        dmem_byte_en_o = BYTE;
        dmem_wr_data_o = {24'h000000, st_byte};
        k_d            = k_q + 2'd1;
        if (k_q == last_k) state_d = DONE;
      end
      DONE: begin
        lsu_done_o    = 1'b1;
        lsu_rd_data_o = wr_q ? 32'h0 : res_q;
        lsu_fault_o   = fault_q;
`ifdef LSU_MISALIGN_TRAP_EN
        lsu_misaligned_o = trap_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    haddr_d  = dmem_addr_o;
    hben_d   = dmem_byte_en_o;
    hwdata_d = dmem_wr_data_o;
    hzext_d  = dmem_zero_extnd_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      zext_q   <= 1'b0;
      wdata_q  <= '0;
      split_q  <= 1'b0;
      fault_q  <= 1'b0;
      k_q      <= '0;
      res_q    <= '0;
      haddr_q  <= '0;
      hben_q   <= '0;
      hwdata_q <= '0;
      hzext_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      zext_q   <= zext_d;
      wdata_q  <= wdata_d;
      split_q  <= split_d;
      fault_q  <= fault_d;
      k_q      <= k_d;
      res_q    <= res_d;
      haddr_q  <= haddr_d;
      hben_q   <= hben_d;
      hwdata_q <= hwdata_d;
      hzext_q  <= hzext_d;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q   <= trap_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-array data_mem model, scoreboard of expected
// completions (result, flags, latency, dmem access count), randomized requests.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int unsigned WORDS = 1024;
  localparam int unsigned BYTES = WORDS * 4;

  logic        clk, reset;
  logic        lsu_req_i, lsu_ready_o, lsu_wr_i, lsu_zero_extnd_i;
  logic [31:0] lsu_addr_i, lsu_wr_data_i, lsu_rd_data_o;
  logic [1:0]  lsu_size_i;
  logic        lsu_done_o, lsu_fault_o, lsu_misaligned_o;
  logic        dmem_req_o, dmem_wr_o, dmem_zero_extnd_o;
  logic [31:0] dmem_addr_o, dmem_wr_data_o, dmem_rd_data_i;
  logic [1:0]  dmem_byte_en_o;

  load_store_unit #(.DMEM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .lsu_req_i(lsu_req_i), .lsu_ready_o(lsu_ready_o), .lsu_wr_i(lsu_wr_i),
    .lsu_addr_i(lsu_addr_i), .lsu_size_i(lsu_size_i), .lsu_zero_extnd_i(lsu_zero_extnd_i),
    .lsu_wr_data_i(lsu_wr_data_i), .lsu_done_o(lsu_done_o), .lsu_rd_data_o(lsu_rd_data_o),
    .lsu_fault_o(lsu_fault_o), .lsu_misaligned_o(lsu_misaligned_o),
    .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_byte_en_o(dmem_byte_en_o),
    .dmem_wr_o(dmem_wr_o), .dmem_wr_data_o(dmem_wr_data_o),
    .dmem_zero_extnd_o(dmem_zero_extnd_o), .dmem_rd_data_i(dmem_rd_data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Golden byte image (updated at issue time) and the data_mem model's own storage.
  logic [7:0] shadow [BYTES];
  logic [7:0] mem    [BYTES];
  logic [31:0] rdq = '0;
  bit loaded = 1'b0;
  assign dmem_rd_data_i = rdq;

  always @(posedge clk) begin
    logic [31:0] v;
    if (!loaded) begin
      for (int i = 0; i < int'(BYTES); i++) mem[i] = shadow[i];
      loaded = 1'b1;
    end
    if (dmem_req_o) begin
      if (dmem_wr_o) begin
        for (int i = 0; i < (1 << dmem_byte_en_o); i++)
          mem[12'(dmem_addr_o + 32'(i))] = 8'(dmem_wr_data_o >> (8 * i));
      end else begin
        v = {mem[12'(dmem_addr_o + 32'd3)], mem[12'(dmem_addr_o + 32'd2)],
             mem[12'(dmem_addr_o + 32'd1)], mem[12'(dmem_addr_o)]};
        case (dmem_byte_en_o)
          2'd0:    rdq <= dmem_zero_extnd_o ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
          2'd1:    rdq <= dmem_zero_extnd_o ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          default: rdq <= v;
        endcase
      end
    end
  end

  typedef struct {
    int unsigned acc;
    int unsigned lat;
    logic [31:0] rd;
    bit          fault;
    bit          mis;
    int unsigned nreq;
    bit          has_k;
    logic [31:0] kv;
    logic [31:0] km;
  } exp_t;
  exp_t q[$];
  int unsigned nreq = 0;

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        nreq = 0;
      end else begin
        if (dmem_req_o) nreq++;
        if (lsu_done_o) begin
          if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("rd_data", lsu_rd_data_o, e.rd);
            check("fault", 32'(lsu_fault_o), 32'(e.fault));
            check("misaligned", 32'(lsu_misaligned_o), 32'(e.mis));
            check("dmem_accesses", 32'(nreq), 32'(e.nreq));
            if (e.has_k) check("directed_value", lsu_rd_data_o & e.km, e.kv);
          end
          nreq = 0;
        end else begin
          check("quiet_outputs", lsu_rd_data_o | 32'(lsu_fault_o) | 32'(lsu_misaligned_o), 32'd0);
        end
      end
    end
  end

  function automatic bit in_range(input logic [31:0] a);
    return (a / 4) < WORDS;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!lsu_ready_o && w < 64) begin
      @(posedge clk);
      #1;
      w++;
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [1:0] sz, input bit zx,
                       input logic [31:0] wd, input bit hk, input logic [31:0] kv,
                       input logic [31:0] km);
    exp_t e;
    int n;
    bit mis, flt;
    logic [31:0] v;
    wait_ready();
    if (!lsu_ready_o) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    n   = 1 << sz;
    mis = (a % n) != 0;
    flt = !in_range(a) || (mis && !in_range(a + 32'd4));
    e = '{acc: cyc, lat: 0, rd: 32'h0, fault: 1'b0, mis: 1'b0, nreq: 0,
          has_k: hk, kv: kv, km: km};
    if (flt) begin
      e.lat = 1; e.fault = 1'b1;
    end else if (TRAP && mis) begin
      e.lat = 1; e.mis = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < n; i++) shadow[12'(a + 32'(i))] = 8'(wd >> (8 * i));
      e.lat  = mis ? n + 1 : 2;
      e.nreq = mis ? n : 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(shadow[12'(a + 32'(i))]) << (8 * i));
      if (!zx && n == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!zx && n == 2 && v[15]) v = v | 32'hFFFF0000;
      e.rd   = v;
      e.lat  = mis ? 5 : 3;
      e.nreq = mis ? 2 : 1;
    end
    q.push_back(e);
    lsu_req_i = 1'b1; lsu_wr_i = wr; lsu_addr_i = a; lsu_size_i = sz;
    lsu_zero_extnd_i = zx; lsu_wr_data_i = wd;
    @(posedge clk);
    #1;
    lsu_req_i = 1'b0;
  endtask

  logic [31:0] specials [6] = '{32'h0000_1000, 32'hFFFF_FFFE, 32'h0000_0FFE,
                                32'h0000_0FFD, 32'h8000_0000, 32'h0000_0FFC};

  initial begin
    logic [31:0] a;
    int r, w;
    for (int i = 0; i < int'(BYTES); i++) shadow[i] = 8'($urandom);
    reset = 1'b1; lsu_req_i = 1'b0; lsu_wr_i = 1'b0; lsu_addr_i = '0;
    lsu_size_i = '0; lsu_zero_extnd_i = 1'b0; lsu_wr_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(lsu_ready_o), 32'd1);
    check("reset_done", 32'(lsu_done_o), 32'd0);
    check("reset_dmem_req", 32'(dmem_req_o), 32'd0);
    check("reset_dmem_bus", dmem_addr_o | dmem_wr_data_o | 32'(dmem_byte_en_o) |
          32'(dmem_wr_o) | 32'(dmem_zero_extnd_o), 32'd0);
    reset = 1'b0;

    // Directed sequence (size: 0=byte, 1=half, 2=word).
    issue(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, 0, 0);
    issue(0, 32'h10, 2'd2, 0, 0, 1, 32'hDEADBEEF, 32'hFFFFFFFF);
    issue(1, 32'h10, 2'd2, 0, 32'h80FF0011, 0, 0, 0);
    issue(0, 32'h13, 2'd0, 0, 0, 1, 32'hFFFFFF80, 32'hFFFFFFFF);
    issue(0, 32'h13, 2'd0, 1, 0, 1, 32'h00000080, 32'hFFFFFFFF);
    issue(1, 32'h10, 2'd2, 0, 32'h44332211, 0, 0, 0);
    issue(1, 32'h14, 2'd2, 0, 32'h88776655, 0, 0, 0);
    issue(0, 32'h11, 2'd2, 0, 0, 1, TRAP ? 32'h0 : 32'h55443322, 32'hFFFFFFFF);
    issue(1, 32'h13, 2'd1, 0, 32'h0000ABCD, 0, 0, 0);
    issue(0, 32'h14, 2'd2, 0, 0, 1, TRAP ? 32'h55 : 32'hAB, 32'h000000FF);
    issue(0, 32'h1000, 2'd2, 0, 0, 1, 32'h0, 32'hFFFFFFFF);
    issue(0, 32'h21, 2'd1, 0, 0, 0, 0, 0);
    issue(1, 32'hFFFFFFFE, 2'd2, 0, 32'h12345678, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = specials[$urandom_range(0, 5)];
      else if (r == 1) a = BYTES - $urandom_range(1, 8);
      else             a = $urandom_range(0, BYTES - 1);
      issue(1'($urandom), a, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, 0, 0, 0);
    end

    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    w = 0;
    for (int i = 0; i < int'(BYTES); i++) if (mem[i] !== shadow[i]) w++;
    check("mem_image", 32'(w), 32'd0);

    // Reset during a multi-cycle load: request is abandoned, no done pulse.
    wait_ready();
    lsu_req_i = 1'b1; lsu_wr_i = 1'b0; lsu_size_i = 2'd2; lsu_zero_extnd_i = 1'b0;
    lsu_addr_i = TRAP ? 32'h10 : 32'h11;
    @(posedge clk);
    #1;
    lsu_req_i = 1'b0;
    // Now in ISSUE; advance to CAPTURE_HI (split) or CAPTURE (trap build, aligned).
    repeat (TRAP ? 1 : 3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(lsu_ready_o), 32'd1);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("no_dmem_after_reset", 32'(nreq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
